// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debounce controller.
package key_debounce_pkg;

   typedef enum logic [2:0] {
      ST_UP      = 3'd0,
      ST_ARM_DN  = 3'd1,
      ST_WAIT_DN = 3'd2,
      ST_DOWN    = 3'd3,
      ST_ARM_UP  = 3'd4,
      ST_WAIT_UP = 3'd5
   } state_t;

   localparam bit          DEF_KEY_ACTIVE_LOW = 1'b1;
   localparam int unsigned DEF_HOLD_PERIODS   = 50;
   localparam int unsigned DEF_ARM_TIMEOUT    = 4;
   localparam int unsigned TIMER_ARM_LATENCY  = 2;
   localparam int unsigned HOLD_CNT_W         = 8;
   localparam int unsigned ARM_CNT_W          = 8;

   // Saturating increment for the hold period counter.
   function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
      return (v == '1) ? v : v + HOLD_CNT_W'(1);
   endfunction

endpackage

// File: rtl/key_debounce_ctrl_sync.sv
// Two-flop synchroniser for the raw key pin, polarity normalisation
// (pressed = 1) and single-cycle edge detect on the normalised level.
module key_sync
   import key_debounce_pkg::*;
#(
   parameter bit KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_s_c,
   output logic key_edge_c
);

   localparam logic RAW_IDLE = KEY_ACTIVE_LOW;

   logic r_sync1;
   logic r_sync2;
   logic r_key_s_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1   <= RAW_IDLE;
         r_sync2   <= RAW_IDLE;
         r_key_s_d <= 1'b0;
      end else begin
         r_sync1   <= key_raw;
         r_sync2   <= r_sync1;
         r_key_s_d <= key_s_c;
      end
   end

   assign key_s_c    = r_sync2 ^ KEY_ACTIVE_LOW;
   assign key_edge_c = key_s_c ^ r_key_s_d;

endmodule

// File: rtl/key_debounce_ctrl.sv
// Debounce controller: drives an external retriggerable one-shot timer and
// commits the key level once the timer expires with no further raw edges.
module key_debounce_ctrl
   import key_debounce_pkg::*;
#(
   parameter bit          KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
   parameter int unsigned HOLD_PERIODS   = DEF_HOLD_PERIODS,
   parameter int unsigned ARM_TIMEOUT    = DEF_ARM_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   input  logic timer_on,
   output logic timer_start,
   output logic key_state,
   output logic key_pressed,
   output logic key_released,
   output logic key_hold,
   output logic err_timer
);

   // The arm window always covers the timer's start-to-on latency.
   localparam int unsigned ARM_LIMIT = (ARM_TIMEOUT > TIMER_ARM_LATENCY) ?
                                       ARM_TIMEOUT : TIMER_ARM_LATENCY + 1;
   localparam logic [HOLD_CNT_W-1:0] HOLD_TGT   = HOLD_CNT_W'(HOLD_PERIODS);
   localparam logic [ARM_CNT_W-1:0]  ARM_LAST   = ARM_CNT_W'(ARM_LIMIT - 1);
   localparam logic [ARM_CNT_W-1:0]  ARM_SETTLE = ARM_CNT_W'(TIMER_ARM_LATENCY);

   logic w_key_s;
   logic w_edge;
   logic w_on_fall;
   logic w_hold_done;
   logic [HOLD_CNT_W-1:0] w_hold_inc;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic [HOLD_CNT_W-1:0] w_hold_cnt_nxt;
   logic [ARM_CNT_W-1:0]  r_arm_cnt;
   logic [ARM_CNT_W-1:0]  w_arm_cnt_nxt;
   logic                  r_on_d;

   logic r_timer_start, w_start_nxt;
   logic r_key_state,   w_key_state_nxt;
   logic r_pressed,     w_pressed_nxt;
   logic r_released,    w_released_nxt;
   logic r_hold,        w_hold_nxt;
   logic r_err_timer,   w_err_nxt;

   key_sync #(
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
   ) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_raw    (key_raw),
      .key_s_c    (w_key_s),
      .key_edge_c (w_edge)
   );

   assign w_on_fall   = r_on_d & ~timer_on;
   assign w_hold_done = (r_hold_cnt >= HOLD_TGT);
   assign w_hold_inc  = sat_inc(r_hold_cnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_UP;
         r_hold_cnt    <= '0;
         r_arm_cnt     <= '0;
         r_on_d        <= 1'b0;
         r_timer_start <= 1'b0;
         r_key_state   <= 1'b0;
         r_pressed     <= 1'b0;
         r_released    <= 1'b0;
         r_hold        <= 1'b0;
         r_err_timer   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_arm_cnt     <= w_arm_cnt_nxt;
         r_on_d        <= timer_on;
         r_timer_start <= w_start_nxt;
         r_key_state   <= w_key_state_nxt;
         r_pressed     <= w_pressed_nxt;
         r_released    <= w_released_nxt;
         r_hold        <= w_hold_nxt;
         r_err_timer   <= w_err_nxt;
      end
   end

   // Raw edges always take priority over timer expiry in every state.
   always_comb begin
      w_state_nxt     = r_state;
      w_hold_cnt_nxt  = r_hold_cnt;
      w_arm_cnt_nxt   = r_arm_cnt;
      w_start_nxt     = 1'b0;
      w_key_state_nxt = r_key_state;
      w_pressed_nxt   = 1'b0;
      w_released_nxt  = 1'b0;
      w_hold_nxt      = 1'b0;
      w_err_nxt       = r_err_timer;

      unique case (r_state)
         ST_UP: begin
            if (w_edge) begin
               w_start_nxt   = 1'b1;
               w_arm_cnt_nxt = '0;
               w_state_nxt   = ST_ARM_DN;
            end
         end

         ST_ARM_DN, ST_ARM_UP: begin
            if (w_edge) begin
               w_start_nxt   = 1'b1;
               w_arm_cnt_nxt = '0;
            end else if (timer_on && (r_arm_cnt >= ARM_SETTLE)) begin
               w_state_nxt = (r_state == ST_ARM_DN) ? ST_WAIT_DN : ST_WAIT_UP;
            end else if (r_arm_cnt >= ARM_LAST) begin
               w_err_nxt = 1'b1;
               if (r_state == ST_ARM_DN) begin
                  w_state_nxt = ST_UP;
               end else begin
                  w_state_nxt = ST_DOWN;
                  w_start_nxt = ~w_hold_done;
               end
            end else begin
               w_arm_cnt_nxt = r_arm_cnt + ARM_CNT_W'(1);
            end
         end

         ST_WAIT_DN: begin
            if (w_edge) begin
               w_start_nxt = 1'b1;
            end else if (!timer_on) begin
               if (w_key_s) begin
                  w_state_nxt     = ST_DOWN;
                  w_key_state_nxt = 1'b1;
                  w_pressed_nxt   = 1'b1;
                  w_hold_cnt_nxt  = '0;
                  w_start_nxt     = 1'b1;
               end else begin
                  w_state_nxt = ST_UP;
               end
            end
         end

         ST_WAIT_UP: begin
            if (w_edge) begin
               w_start_nxt = 1'b1;
            end else if (!timer_on) begin
               if (!w_key_s) begin
                  w_state_nxt     = ST_UP;
                  w_key_state_nxt = 1'b0;
                  w_released_nxt  = 1'b1;
               end else begin
                  // Glitch while held: resume hold timing without resetting it.
                  w_state_nxt = ST_DOWN;
                  w_start_nxt = ~w_hold_done;
               end
            end
         end

         ST_DOWN: begin
            if (w_edge) begin
               w_start_nxt   = 1'b1;
               w_arm_cnt_nxt = '0;
               w_state_nxt   = ST_ARM_UP;
            end else if (w_on_fall && !w_hold_done) begin
               w_hold_cnt_nxt = w_hold_inc;
               if (w_hold_inc >= HOLD_TGT) begin
                  w_hold_nxt = 1'b1;
               end else begin
                  w_start_nxt = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = ST_UP;
         end
      endcase
   end

   assign timer_start  = r_timer_start;
   assign key_state    = r_key_state;
   assign key_pressed  = r_pressed;
   assign key_released = r_released;
   assign key_hold     = r_hold;
   assign err_timer    = r_err_timer;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with a 10-count one-shot timer model.
module tb_key_debounce_ctrl;
   import key_debounce_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic key_raw;
   logic timer_on;
   logic timer_start;
   logic key_state;
   logic key_pressed;
   logic key_released;
   logic key_hold;
   logic err_timer;
   logic dead;

   logic       t_start_d = 1'b0;
   logic       t_on      = 1'b0;
   logic [7:0] t_cnt     = 8'd0;

   int n_chk = 0;
   int n_bad = 0;
   int cyc;
   int n_start, n_press, n_rel, n_hold, n_ovl;
   int c_start, c_press, c_hold;

   always #5 clk = ~clk;

   // Timer model: on rises 2 cycles after start, stays high 10 cycles, retriggerable.
   always @(posedge clk) begin
      t_start_d <= timer_start;
      if (t_start_d) begin
         t_cnt <= 8'd10;
         t_on  <= 1'b1;
      end else if (t_cnt != 8'd0) begin
         t_cnt <= t_cnt - 8'd1;
         if (t_cnt == 8'd1) t_on <= 1'b0;
      end
   end

   assign timer_on = t_on & ~dead;

   key_debounce_ctrl #(
      .KEY_ACTIVE_LOW (1'b1),
      .HOLD_PERIODS   (3),
      .ARM_TIMEOUT    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_raw      (key_raw),
      .timer_on     (timer_on),
      .timer_start  (timer_start),
      .key_state    (key_state),
      .key_pressed  (key_pressed),
      .key_released (key_released),
      .key_hold     (key_hold),
      .err_timer    (err_timer)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic mark();
      cyc     = 0;
      n_start = 0; n_press = 0; n_rel = 0; n_hold = 0;
      c_start = -1; c_press = -1; c_hold = -1;
   endtask

   // Sample the current cycle at the falling edge, then advance one cycle.
   task automatic tick();
      @(negedge clk);
      if (timer_start === 1'b1) begin
         if (c_start < 0) c_start = cyc;
         n_start++;
      end
      if (key_pressed === 1'b1) begin
         if (c_press < 0) c_press = cyc;
         n_press++;
      end
      if (key_released === 1'b1) n_rel++;
      if (key_hold === 1'b1) begin
         if (c_hold < 0) c_hold = cyc;
         n_hold++;
      end
      if (32'(key_pressed) + 32'(key_released) + 32'(key_hold) > 32'd1) n_ovl++;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   initial begin
      n_ovl   = 0;
      dead    = 1'b0;
      key_raw = 1'b1;
      rst_n   = 1'b0;
      mark();
      run_to(3);
      chk_eq("rst_outputs", 32'({timer_start, key_state, key_pressed, key_released, key_hold, err_timer}), 32'd0);
      chk_eq("rst_state", 32'(dut.r_state), 32'(ST_UP));
      rst_n = 1'b1;
      run_to(8);

      // Clean press, then hold through three timer periods.
      mark();
      key_raw = 1'b0;
      run_to(2);
      chk_eq("press_no_early_start", 32'(timer_start), 32'd0);
      run_to(3);
      chk_eq("press_start_lat", 32'(timer_start), 32'd1);
      run_to(15);
      chk_eq("press_state_before", 32'(key_state), 32'd0);
      run_to(16);
      chk_eq("press_pulse", 32'(key_pressed), 32'd1);
      chk_eq("press_state", 32'(key_state), 32'd1);
      run_to(17);
      chk_eq("press_pulse_width", 32'(key_pressed), 32'd0);
      run_to(100);
      chk_eq("press_count", 32'(n_press), 32'd1);
      chk_eq("hold_cycle", 32'(c_hold), 32'd55);
      chk_eq("hold_count", 32'(n_hold), 32'd1);
      chk_eq("hold_starts", 32'(n_start), 32'd4);
      chk_eq("hold_state", 32'(key_state), 32'd1);

      // Release after hold.
      mark();
      key_raw = 1'b1;
      run_to(16);
      chk_eq("rel_pulse", 32'(key_released), 32'd1);
      chk_eq("rel_state", 32'(key_state), 32'd0);
      run_to(40);
      chk_eq("rel_count", 32'(n_rel), 32'd1);
      chk_eq("rel_no_hold", 32'(n_hold), 32'd0);

      // Bounce: three synchronised edges, one commit.
      mark();
      key_raw = 1'b0;
      tick();
      key_raw = 1'b1;
      tick();
      key_raw = 1'b0;
      run_to(18);
      chk_eq("bounce_starts", 32'(n_start), 32'd3);
      run_to(30);
      chk_eq("bounce_press_count", 32'(n_press), 32'd1);
      chk_eq("bounce_press_cycle", 32'(c_press), 32'd18);
      mark();
      key_raw = 1'b1;
      run_to(40);
      chk_eq("bounce_rel_count", 32'(n_rel), 32'd1);
      chk_eq("bounce_rel_state", 32'(key_state), 32'd0);

      // Glitch: two-cycle low pulse must not commit.
      mark();
      key_raw = 1'b0;
      tick();
      tick();
      key_raw = 1'b1;
      run_to(40);
      chk_eq("glitch_starts", 32'(n_start), 32'd2);
      chk_eq("glitch_no_press", 32'(n_press), 32'd0);
      chk_eq("glitch_state", 32'(key_state), 32'd0);
      chk_eq("glitch_fsm_up", 32'(dut.r_state), 32'(ST_UP));

      // Dead timer: arm timeout sets the sticky error.
      dead = 1'b1;
      mark();
      key_raw = 1'b0;
      run_to(6);
      chk_eq("dead_err_early", 32'(err_timer), 32'd0);
      chk_eq("dead_in_arm", 32'(dut.r_state), 32'(ST_ARM_DN));
      run_to(7);
      chk_eq("dead_err", 32'(err_timer), 32'd1);
      chk_eq("dead_back_up", 32'(dut.r_state), 32'(ST_UP));
      dead    = 1'b0;
      key_raw = 1'b1;
      run_to(47);
      chk_eq("dead_err_sticky", 32'(err_timer), 32'd1);
      chk_eq("dead_no_press", 32'(n_press), 32'd0);
      chk_eq("dead_state", 32'(key_state), 32'd0);

      // Reset while waiting for the timer to expire.
      mark();
      key_raw = 1'b0;
      run_to(8);
      chk_eq("rstw_in_wait", 32'(dut.r_state), 32'(ST_WAIT_DN));
      rst_n   = 1'b0;
      key_raw = 1'b1;
      run_to(9);
      chk_eq("rstw_outputs", 32'({timer_start, key_state, key_pressed, key_released, key_hold, err_timer}), 32'd0);
      chk_eq("rstw_state", 32'(dut.r_state), 32'(ST_UP));
      run_to(10);
      rst_n = 1'b1;
      run_to(40);
      chk_eq("rstw_no_press", 32'(n_press), 32'd0);
      chk_eq("rstw_key_state", 32'(key_state), 32'd0);

      chk_eq("pulse_overlap", 32'(n_ovl), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
